neuron_core_wb_slave: RTL and testbench
=======================================

NEURON_CORE_WB_SLAVE -- requirements
Module: neuron_core_wb_slave

Interface
REQ-001 SHALL have parameter BASE_HI, default 16'h3000; wbs_adr_i[31:16] value that selects this core.
REQ-002 SHALL have parameter STALL_MAX, default 8'd255; maximum stall cycles for a write to the image-packet region.
REQ-003 Port wb_clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 Port wb_rst_i  input  1  reset; synchronous, active-high.
REQ-005 Port wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-006 Port wbs_sel_i  input  4  byte lanes; wbs_adr_i  input  32  address; wbs_dat_i  input  32  write data.
REQ-007 Port wbs_ack_o  output  1  Wishbone acknowledge; wbs_dat_o  output  32  registered read data.
REQ-008 Port addr_o  output  32  latched address, driven to the core address decoder.
REQ-009 Port wr_en_o, rd_en_o  output  1 each  single-cycle access strobes to the decoded target.
REQ-010 Port wdata_o  output  32  latched write data; wsel_o  output  4  latched byte lanes.
REQ-011 Port rdata_i  input  32  target read data, valid the cycle after rd_en_o.
REQ-012 Port core_busy_i  input  1  core is processing the current image packet.
REQ-013 Port err_o  output  1  sticky flag: an image-packet write timed out.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, WAIT_RD and ACK.
REQ-015 IDLE: on wbs_cyc_i&wbs_stb_i, latch adr/dat/sel/we into addr_o/wdata_o/wsel_o/internal we and go to ACCESS.
REQ-016 A request is in range iff addr_o[31:16]==BASE_HI.
REQ-017 Image-packet write = in-range write with addr_o[15:14]==2'b11.
REQ-018 ACCESS, image-packet write with core_busy_i=1: stay in ACCESS, no strobe, increment 8-bit stall counter.
REQ-019 ACCESS, stall counter == STALL_MAX: set err_o, issue no strobe, go to ACK.
REQ-020 ACCESS otherwise, in-range write: wr_en_o=1 for exactly this cycle, then go to ACK.
REQ-021 ACCESS otherwise, in-range read: rd_en_o=1 for exactly this cycle, then go to WAIT_RD.
REQ-022 ACCESS otherwise, out-of-range: no strobe; read loads wbs_dat_o=0; go to ACK.
REQ-023 WAIT_RD: load wbs_dat_o<=rdata_i, then go to ACK.
REQ-024 ACK: wbs_ack_o=1 for exactly one cycle, then IDLE; stall counter cleared.
REQ-025 Latency, stb sampled in IDLE at cycle 0: write ack at cycle 2; read ack at cycle 3.
REQ-026 Only one outstanding transaction; no new request accepted until IDLE.
REQ-027 wbs_cyc_i=0 in ACCESS or WAIT_RD: return to IDLE with no ack and no further strobe; a write not yet strobed is dropped.
REQ-028 wbs_dat_o SHALL hold its value except at WAIT_RD and out-of-range reads.
REQ-029 wr_en_o and rd_en_o SHALL never be high together.

Reset
REQ-030 While wb_rst_i=1 at a clock edge: FSM->IDLE.
REQ-031 On reset: wbs_ack_o, wr_en_o, rd_en_o, err_o=0.
REQ-032 On reset: wbs_dat_o, addr_o, wdata_o=0; wsel_o=0; stall counter=0.
REQ-033 Reset mid-transaction SHALL abort it with no ack and no strobe.
REQ-034 err_o SHALL clear only on reset.

Structure
REQ-035 Shared package SHALL hold the state encoding, BASE_HI default, region code 2'b11 and STALL_MAX default.
REQ-036 No sub-module SHALL be used; the stall counter is inline.

Verification
REQ-037 Write 0x3000_0010 data 0xA5A5_0001 -> wr_en_o at cycle 1 with addr_o/wdata_o matching; ack at cycle 2 only.
REQ-038 Read 0x3000_4020, rdata_i=0x1234_5678 -> rd_en_o at cycle 1; ack at cycle 3 with wbs_dat_o=0x1234_5678.
REQ-039 Read 0x3100_0000 -> no strobe; ack with wbs_dat_o=0.
REQ-040 Write 0x3000_C001 with core_busy_i high 10 cycles -> wr_en_o one cycle after busy falls; ack follows.
REQ-041 Write 0x3000_C002 with busy stuck high -> err_o=1; ack after STALL_MAX stall cycles; no wr_en_o.
REQ-042 Drop wbs_cyc_i during stall, then assert wb_rst_i in WAIT_RD -> no ack, no write; all outputs 0 next cycle.

Source files
------------

// File: rtl/neuron_core_pkg.sv
// rtl/neuron_core_pkg.sv - shared encodings and defaults for the neuron core Wishbone slave
package neuron_core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [15:0] BASE_HI_DEFAULT   = 16'h3000;
    localparam logic [1:0]  REGION_IMG_PKT    = 2'b11;
    localparam logic [7:0]  STALL_MAX_DEFAULT = 8'd255;

endpackage

// File: rtl/neuron_core_wb_slave.sv
// rtl/neuron_core_wb_slave.sv - Wishbone classic slave bridging to the neuron core decoder
module neuron_core_wb_slave
    import neuron_core_pkg::*;
#(
    parameter logic [15:0] BASE_HI   = BASE_HI_DEFAULT,
    parameter logic [7:0]  STALL_MAX = STALL_MAX_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] addr_o,
    output logic        wr_en_o,
    output logic        rd_en_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wsel_o,
    input  logic [31:0] rdata_i,
    input  logic        core_busy_i,
    output logic        err_o
);

    state_t     state;
    state_t     state_nxt;
    logic       we_q;
    logic [7:0] stall_cnt;
    logic       in_range;
    logic       img_write;
    logic       stall_inc;
    logic       set_err;
    logic       load_zero;

    assign in_range  = (addr_o[31:16] == BASE_HI);
    assign img_write = in_range && we_q && (addr_o[15:14] == REGION_IMG_PKT);

    // Timeout is checked before busy so a saturated counter never wraps.
    always_comb begin
        state_nxt = state;
        wr_en_o   = 1'b0;
        rd_en_o   = 1'b0;
        wbs_ack_o = 1'b0;
        stall_inc = 1'b0;
        set_err   = 1'b0;
        load_zero = 1'b0;
        case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (img_write && (stall_cnt == STALL_MAX)) begin
                    set_err   = 1'b1;
                    state_nxt = ACK;
                end else if (img_write && core_busy_i) begin
                    stall_inc = 1'b1;
                end else if (in_range && we_q) begin
                    wr_en_o   = 1'b1;
                    state_nxt = ACK;
                end else if (in_range) begin
                    rd_en_o   = 1'b1;
                    state_nxt = WAIT_RD;
                end else begin
                    load_zero = !we_q;
                    state_nxt = ACK;
                end
            end
            WAIT_RD: begin
                state_nxt = wbs_cyc_i ? ACK : IDLE;
            end
            ACK: begin
                wbs_ack_o = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            addr_o    <= '0;
            wdata_o   <= '0;
            wsel_o    <= '0;
            we_q      <= 1'b0;
            stall_cnt <= '0;
            err_o     <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && wbs_cyc_i && wbs_stb_i) begin
                addr_o  <= wbs_adr_i;
                wdata_o <= wbs_dat_i;
                wsel_o  <= wbs_sel_i;
                we_q    <= wbs_we_i;
            end
            stall_cnt <= stall_inc ? stall_cnt + 8'd1 : 8'd0;
            if (set_err) begin
                err_o <= 1'b1;
            end
            if (load_zero) begin
                wbs_dat_o <= '0;
            end else if (state == WAIT_RD && wbs_cyc_i) begin
                wbs_dat_o <= rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_neuron_core_wb_slave.sv
// tb/tb_neuron_core_wb_slave.sv - self-checking bench for neuron_core_wb_slave
module tb_neuron_core_wb_slave;

    localparam int          NCYC      = 2048;
    localparam logic [15:0] BASE_HI   = 16'h3000;
    localparam int          STALL_MAX = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r, addr_o, wdata_o, rdata;
    logic        wr_en, rd_en, busy, err;
    logic [3:0]  wsel_o;

    always #5 clk = ~clk;

    neuron_core_wb_slave dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_w),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_r),
        .addr_o      (addr_o),
        .wr_en_o     (wr_en),
        .rd_en_o     (rd_en),
        .wdata_o     (wdata_o),
        .wsel_o      (wsel_o),
        .rdata_i     (rdata),
        .core_busy_i (busy),
        .err_o       (err)
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // Expected-event schedule, indexed by cycle; filled from the latency rules.
    bit          exp_wr  [NCYC];
    bit          exp_rd  [NCYC];
    bit          exp_ack [NCYC];
    bit          upd_lat [NCYC];
    logic [31:0] upd_addr[NCYC];
    logic [31:0] upd_wd  [NCYC];
    logic [3:0]  upd_ws  [NCYC];
    bit          upd_dat [NCYC];
    logic [31:0] upd_dv  [NCYC];
    bit          upd_err [NCYC];
    bit          upd_rst [NCYC];

    logic [31:0] m_addr = '0, m_wdata = '0, m_dat = '0;
    logic [3:0]  m_wsel = '0;
    logic        m_err = 1'b0;
    bit          check_en = 1'b0;

    int          last_wr_cycle = -1, last_rd_cycle = -1, last_ack_cycle = -1;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0, last_ack_dat = '0;
    int          strobe_count = 0, ack_count = 0;

    always @(negedge clk) begin
        if (check_en && cycle < NCYC) begin
            if (upd_rst[cycle]) begin
                m_addr = '0; m_wdata = '0; m_wsel = '0; m_dat = '0; m_err = 1'b0;
            end
            if (upd_lat[cycle]) begin
                m_addr = upd_addr[cycle]; m_wdata = upd_wd[cycle]; m_wsel = upd_ws[cycle];
            end
            if (upd_dat[cycle]) m_dat = upd_dv[cycle];
            if (upd_err[cycle]) m_err = 1'b1;
            chk("ack",    {31'd0, ack},   {31'd0, exp_ack[cycle]});
            chk("wr_en",  {31'd0, wr_en}, {31'd0, exp_wr[cycle]});
            chk("rd_en",  {31'd0, rd_en}, {31'd0, exp_rd[cycle]});
            chk("excl",   {31'd0, wr_en & rd_en}, 32'd0);
            chk("addr",   addr_o,  m_addr);
            chk("wdata",  wdata_o, m_wdata);
            chk("wsel",   {28'd0, wsel_o}, {28'd0, m_wsel});
            chk("dat_o",  dat_r,   m_dat);
            chk("err",    {31'd0, err}, {31'd0, m_err});
            if (wr_en === 1'b1) begin
                last_wr_cycle = cycle; last_wr_addr = addr_o; last_wr_data = wdata_o;
                strobe_count++;
            end
            if (rd_en === 1'b1) begin
                last_rd_cycle = cycle; strobe_count++;
            end
            if (ack === 1'b1) begin
                last_ack_cycle = cycle; last_ack_dat = dat_r; ack_count++;
            end
        end
    end

    task automatic schedule(input int t0, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit w, input int busy_len,
                            input logic [31:0] rd, output int ack_at);
        bit hit, img;
        hit = (a[31:16] == BASE_HI);
        img = hit && w && (a[15:14] == 2'b11);
        upd_lat[t0+1] = 1'b1; upd_addr[t0+1] = a; upd_wd[t0+1] = d; upd_ws[t0+1] = s;
        if (img && busy_len >= STALL_MAX) begin
            ack_at = t0 + 2 + STALL_MAX;
            upd_err[ack_at] = 1'b1;
        end else if (img) begin
            exp_wr[t0+1+busy_len] = 1'b1;
            ack_at = t0 + 2 + busy_len;
        end else if (hit && w) begin
            exp_wr[t0+1] = 1'b1;
            ack_at = t0 + 2;
        end else if (hit) begin
            exp_rd[t0+1] = 1'b1;
            ack_at = t0 + 3;
            upd_dat[ack_at] = 1'b1; upd_dv[ack_at] = rd;
        end else begin
            ack_at = t0 + 2;
            if (!w) begin
                upd_dat[ack_at] = 1'b1; upd_dv[ack_at] = '0;
            end
        end
        exp_ack[ack_at] = 1'b1;
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit w, input logic [31:0] rd, input bit b);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; rdata = rd; busy = b;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit w, input int busy_len, input logic [31:0] rd,
                           output int t0);
        int ack_at;
        @(posedge clk); #1;
        t0 = cycle;
        start_req(a, d, s, w, rd, busy_len > 0);
        schedule(t0, a, d, s, w, busy_len, rd, ack_at);
        while (cycle < ack_at) begin
            @(posedge clk); #1;
            if (cycle == t0 + busy_len + 1) busy = 1'b0;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; busy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int t0, t1, sc, ac;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0;
        rdata = '0; busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_en = 1'b1;

        run_txn(32'h3000_0010, 32'hA5A5_0001, 4'hF, 1'b1, 0, 32'h0, t0);
        chk("w_en_lat",  last_wr_cycle - t0, 32'd1);
        chk("w_ack_lat", last_ack_cycle - t0, 32'd2);
        chk("w_addr",    last_wr_addr, 32'h3000_0010);
        chk("w_data",    last_wr_data, 32'hA5A5_0001);

        run_txn(32'h3000_4020, 32'h0, 4'hF, 1'b0, 0, 32'h1234_5678, t0);
        chk("r_en_lat",  last_rd_cycle - t0, 32'd1);
        chk("r_ack_lat", last_ack_cycle - t0, 32'd3);
        chk("r_data",    last_ack_dat, 32'h1234_5678);

        sc = strobe_count;
        run_txn(32'h3100_0000, 32'h0, 4'hF, 1'b0, 0, 32'hDEAD_BEEF, t0);
        chk("oor_ack_lat", last_ack_cycle - t0, 32'd2);
        chk("oor_data",    last_ack_dat, 32'h0);
        chk("oor_nostrobe", strobe_count - sc, 32'd0);

        run_txn(32'h2FFF_0004, 32'h0BAD_F00D, 4'h3, 1'b1, 0, 32'h0, t0);
        run_txn(32'h3000_8004, 32'h5555_AAAA, 4'h5, 1'b1, 0, 32'h0, t0);
        run_txn(32'h3000_C010, 32'h0, 4'hC, 1'b0, 0, 32'hCAFE_0042, t0);
        chk("img_rd_data", last_ack_dat, 32'hCAFE_0042);

        run_txn(32'h3000_C001, 32'h0000_00C1, 4'hF, 1'b1, 10, 32'h0, t0);
        chk("stall_wr_lat",  last_wr_cycle - t0, 32'd11);
        chk("stall_ack_lat", last_ack_cycle - t0, 32'd12);

        sc = strobe_count;
        run_txn(32'h3000_C002, 32'h0000_00C2, 4'hF, 1'b1, 1000, 32'h0, t0);
        chk("to_ack_lat", last_ack_cycle - t0, 32'd257);
        chk("to_err",     {31'd0, err}, 32'd1);
        chk("to_nowrite", strobe_count - sc, 32'd0);

        run_txn(32'h3000_0044, 32'h0, 4'hF, 1'b0, 0, 32'h0000_7777, t0);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Abandon a stalled packet write, then reset in the middle of a read.
        sc = strobe_count; ac = ack_count;
        @(posedge clk); #1;
        t0 = cycle;
        start_req(32'h3000_C003, 32'h0000_00C3, 4'hF, 1'b1, 32'h0, 1'b1);
        upd_lat[t0+1] = 1'b1; upd_addr[t0+1] = 32'h3000_C003;
        upd_wd[t0+1] = 32'h0000_00C3; upd_ws[t0+1] = 4'hF;
        while (cycle < t0 + 5) begin @(posedge clk); #1; end
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        t1 = cycle;
        start_req(32'h3000_0100, 32'h0, 4'hF, 1'b0, 32'h9999_1111, 1'b0);
        exp_rd[t1+1] = 1'b1;
        upd_lat[t1+1] = 1'b1; upd_addr[t1+1] = 32'h3000_0100;
        upd_wd[t1+1] = 32'h0; upd_ws[t1+1] = 4'hF;
        while (cycle < t1 + 2) begin @(posedge clk); #1; end
        rst = 1'b1;
        upd_rst[t1+3] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("drop_noack",  ack_count - ac, 32'd0);
        chk("drop_strobes", strobe_count - sc, 32'd1);
        chk("rst_err",     {31'd0, err}, 32'd0);
        chk("rst_addr",    addr_o, 32'd0);

        run_txn(32'h3000_0020, 32'h1357_9BDF, 4'h9, 1'b1, 0, 32'h0, t0);
        chk("post_rst_ack_lat", last_ack_cycle - t0, 32'd2);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
